uart_rx: RTL and testbench

UART receiver for the 8N1 serial link. It consumes the oversampling tick from the shared baud-rate generator, which runs at 8 ticks per bit (9600 baud on the 100 MHz system clock). It recovers one byte per frame from the asynchronous `rx` pin and presents it to downstream logic (FIFO/command decoder) with a one-cycle `rx_done` strobe. It is the receive-side counterpart of the baud generator and the UART transmitter in the top-level serial path.

---
 rtl/uart_rx_if.sv | 22 ++
 rtl/uart_rx.sv | 126 ++++++++++++
 tb/tb_uart_rx.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// uart_rx serial-side and byte-side signal bundle.
// master drives the line and tick, slave is the receiver.
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic                 b_tick;
    logic                 rx;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_done;
    logic                 rx_busy;
    logic                 frame_err;

    modport master (
        output b_tick, rx,
        input  rx_data, rx_done, rx_busy, frame_err
    );

    modport slave (
        input  b_tick, rx,
        output rx_data, rx_done, rx_busy, frame_err
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver, oversampled by the shared baud tick.
// Delivers one byte per frame with a one-cycle done strobe.
module uart_rx #(
    parameter int OVERSAMPLE = 8,
    parameter int DATA_BITS  = 8
) (
    input  logic     clk,
    input  logic     rst,
    uart_rx_if.slave bus
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t               r_state, w_state;
    logic [1:0]           r_sync;
    logic [TW-1:0]        r_tick, w_tick;
    logic [BW-1:0]        r_bit, w_bit;
    logic [DATA_BITS-1:0] r_shift, w_shift;
    logic [DATA_BITS-1:0] r_data, w_data;
    logic                 r_done, w_done;
    logic                 r_ferr, w_ferr;
    logic                 w_rx_s;

    assign w_rx_s = r_sync[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= 2'b11;
            r_state <= S_IDLE;
            r_tick  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_done  <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], bus.rx};
            r_state <= w_state;
            r_tick  <= w_tick;
            r_bit   <= w_bit;
            r_shift <= w_shift;
            r_data  <= w_data;
            r_done  <= w_done;
            r_ferr  <= w_ferr;
        end
    end

    always_comb begin
        w_state = r_state;
        w_tick  = r_tick;
        w_bit   = r_bit;
        w_shift = r_shift;
        w_data  = r_data;
        w_done  = 1'b0;
        w_ferr  = r_ferr;
        case (r_state)
            S_IDLE: begin
                if (!w_rx_s) begin
                    w_state = S_START;
                    w_tick  = '0;
                end
            end
            S_START: begin
                if (bus.b_tick) begin
                    if (r_tick == HALF) begin
                        if (!w_rx_s) begin
                            w_state = S_DATA;
                            w_tick  = '0;
                            w_bit   = '0;
                        end else begin
                            w_state = S_IDLE;
                        end
                    end else begin
                        w_tick = r_tick + 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (bus.b_tick) begin
                    if (r_tick == FULL) begin
                        w_shift = {w_rx_s, r_shift[DATA_BITS-1:1]};
                        w_tick  = '0;
                        if (r_bit == LAST) w_state = S_STOP;
                        else               w_bit   = r_bit + 1'b1;
                    end else begin
                        w_tick = r_tick + 1'b1;
                    end
                end
            end
            S_STOP: begin
                if (bus.b_tick) begin
                    if (r_tick == FULL) begin
                        w_data  = r_shift;
                        w_done  = 1'b1;
                        w_ferr  = ~w_rx_s;
                        w_tick  = '0;
                        // a low stop bit parks in BREAK so a held-low line cannot re-arm START
                        w_state = w_rx_s ? S_IDLE : S_BREAK;
                    end else begin
                        w_tick = r_tick + 1'b1;
                    end
                end
            end
            S_BREAK: begin
                if (w_rx_s) w_state = S_IDLE;
            end
            default: w_state = S_IDLE;
        endcase
    end

    assign bus.rx_data   = r_data;
    assign bus.rx_done   = r_done;
    assign bus.rx_busy   = (r_state != S_IDLE);
    assign bus.frame_err = r_ferr;
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: tick-paced serial driver,
// done-strobe monitor and a queue of expected {frame_err, byte}.
module tb_uart_rx;
    logic clk;
    logic rst;
    logic tick_en;
    int   tdiv;
    int   n_checks;
    int   n_err;
    logic [7:0] last_byte;
    logic [8:0] got_q[$];
    logic [8:0] exp_q[$];

    uart_rx_if bus ();

    uart_rx dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // tick every 4 clk, changed 1ns after the edge so it is stable at the next one
    initial begin
        bus.b_tick = 1'b0;
        tdiv = 0;
        forever begin
            @(posedge clk);
            #1;
            tdiv = (tdiv + 1) % 4;
            bus.b_tick = tick_en && (tdiv == 0);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.rx_done === 1'b1)
                got_q.push_back({bus.frame_err, bus.rx_data});
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        int seen;
        int guard;
        seen  = 0;
        guard = 0;
        while (seen < n) begin
            @(negedge clk);
            guard++;
            if (bus.b_tick) seen++;
            if (guard > 2000) begin
                chk("tick_timeout", 32'(guard), 32'd2000);
                break;
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        bus.rx = 1'b0;
        wait_ticks(8);
        for (int i = 0; i < 8; i++) begin
            bus.rx = d[i];
            wait_ticks(8);
        end
        bus.rx = stop;
        wait_ticks(8);
    endtask

    task automatic expect_frame(input logic [7:0] d, input logic stop);
        exp_q.push_back({~stop, d});
        last_byte = d;
    endtask

    task automatic check_q(input string tag);
        logic [8:0] e;
        logic [8:0] g;
        chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            chk({tag, "_data"}, 32'(g[7:0]), 32'(e[7:0]));
            chk({tag, "_ferr"}, 32'(g[8]), 32'(e[8]));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_data"}, 32'(bus.rx_data), 32'h0);
        chk({tag, "_done"}, 32'(bus.rx_done), 32'h0);
        chk({tag, "_busy"}, 32'(bus.rx_busy), 32'h0);
        chk({tag, "_ferr"}, 32'(bus.frame_err), 32'h0);
    endtask

    initial begin
        logic [7:0] d;
        int gap;
        n_checks  = 0;
        n_err     = 0;
        last_byte = 8'h00;
        tick_en   = 1'b1;
        rst       = 1'b1;
        bus.rx    = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outs("reset");
        rst = 1'b0;
        wait_ticks(8);

        send_frame(8'hA5, 1'b1);
        expect_frame(8'hA5, 1'b1);
        wait_ticks(8);
        check_q("a5");
        chk("a5_busy", 32'(bus.rx_busy), 32'h0);

        send_frame(8'h00, 1'b1);
        expect_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        expect_frame(8'hFF, 1'b1);
        wait_ticks(8);
        check_q("b2b");

        bus.rx = 1'b0;
        repeat (6) @(negedge clk);
        chk("glitch_busy_hi", 32'(bus.rx_busy), 32'h1);
        repeat (2) @(negedge clk);
        bus.rx = 1'b1;
        repeat (40) @(negedge clk);
        chk("glitch_busy_lo", 32'(bus.rx_busy), 32'h0);
        chk("glitch_hold", 32'(bus.rx_data), 32'(last_byte));
        check_q("glitch");

        send_frame(8'h3C, 1'b0);
        expect_frame(8'h3C, 1'b0);
        wait_ticks(20 * 8);
        chk("break_busy", 32'(bus.rx_busy), 32'h1);
        chk("break_ferr", 32'(bus.frame_err), 32'h1);
        check_q("break");
        bus.rx = 1'b1;
        repeat (5) @(negedge clk);
        chk("break_release", 32'(bus.rx_busy), 32'h0);
        wait_ticks(8);
        send_frame(8'h55, 1'b1);
        expect_frame(8'h55, 1'b1);
        wait_ticks(8);
        check_q("after_break");

        d = 8'h81;
        bus.rx = 1'b0;
        wait_ticks(8);
        for (int i = 0; i < 4; i++) begin
            bus.rx = d[i];
            wait_ticks(8);
        end
        bus.rx = d[4];
        wait_ticks(4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.rx = 1'b1;
        chk_reset_outs("midrst");
        wait_ticks(24);
        check_q("midrst_drop");
        send_frame(8'h7E, 1'b1);
        expect_frame(8'h7E, 1'b1);
        wait_ticks(8);
        check_q("after_rst");

        fork
            send_frame(8'hC3, 1'b1);
            begin
                wait_ticks(8 * 3 + 3);
                tick_en = 1'b0;
                repeat (100) @(negedge clk);
                chk("stall_busy", 32'(bus.rx_busy), 32'h1);
                chk("stall_nodone", 32'(got_q.size()), 32'h0);
                tick_en = 1'b1;
            end
        join
        expect_frame(8'hC3, 1'b1);
        wait_ticks(8);
        check_q("stall");

        for (int n = 0; n < 10; n++) begin
            d   = 8'($urandom);
            gap = $urandom_range(0, 2);
            send_frame(d, 1'b1);
            expect_frame(d, 1'b1);
            wait_ticks(gap * 8);
        end
        wait_ticks(8);
        check_q("random");
        chk("random_hold", 32'(bus.rx_data), 32'(last_byte));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
